// File: rtl/ov7670_config_seq.sv
// OV7670 power-up sequencer: walks a table of {register, value} pairs and hands
// each one to the I2C sender, waiting a fixed time after the soft reset.
module ov7670_config_seq #(
  parameter logic [7:0]  CAM_ID       = 8'h42,
  parameter logic [23:0] DELAY_CYCLES = 24'd250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       taken,
  output logic       send,
  output logic [7:0] id,
  output logic [7:0] regis,
  output logic [7:0] value,
  output logic       done,
  output logic       busy,
  output logic [5:0] cmd_index
);

  localparam logic [15:0] WORD_DELAY = 16'hFFF0;
  localparam logic [15:0] WORD_END   = 16'hFFFF;
  // A zero-length delay still spends one cycle in DELAY.
  localparam logic [23:0] DELAY_LOAD =
    (DELAY_CYCLES == 24'd0) ? 24'd0 : DELAY_CYCLES - 24'd1;

  typedef enum logic [1:0] {
    S_FETCH,
    S_SEND,
    S_DELAY,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  addr_q, addr_d;
  logic [23:0] counter_q, counter_d;
  logic [7:0]  regis_q, regis_d;
  logic [7:0]  value_q, value_d;
  logic        send_q, send_d;
  logic        done_q, done_d;
  logic [15:0] rom_word;

  always_comb begin
    rom_word = WORD_END;
    case (addr_q)
      6'd0:    rom_word = 16'h1280;
      6'd1:    rom_word = WORD_DELAY;
      6'd2:    rom_word = 16'h1204;
      6'd3:    rom_word = 16'h40D0;
      6'd4:    rom_word = 16'h8C00;
      6'd5:    rom_word = 16'h1101;
      6'd6:    rom_word = 16'h0C00;
      6'd7:    rom_word = 16'h3E00;
      default: rom_word = WORD_END;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    counter_d = counter_q;
    regis_d   = regis_q;
    value_d   = value_q;
    send_d    = send_q;
    done_d    = done_q;
    case (state_q)
      S_FETCH: begin
        {regis_d, value_d} = rom_word;
        if (rom_word == WORD_END) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (rom_word == WORD_DELAY) begin
          state_d   = S_DELAY;
          counter_d = DELAY_LOAD;
          addr_d    = addr_q + 6'd1;
        end else begin
          state_d = S_SEND;
          send_d  = 1'b1;
        end
      end
      S_SEND: begin
        if (taken) begin
          send_d  = 1'b0;
          addr_d  = addr_q + 6'd1;
          state_d = S_FETCH;
        end
      end
      S_DELAY: begin
        send_d = 1'b0;
        if (counter_q == 24'd0) begin
          state_d = S_FETCH;
        end else begin
          counter_d = counter_q - 24'd1;
        end
      end
      S_DONE: begin
        send_d = 1'b0;
        done_d = 1'b1;
        if (start) begin
          addr_d  = 6'd0;
          done_d  = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
        send_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      addr_q    <= 6'd0;
      counter_q <= 24'd0;
      regis_q   <= 8'hFF;
      value_q   <= 8'hFF;
      send_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      counter_q <= counter_d;
      regis_q   <= regis_d;
      value_q   <= value_d;
      send_q    <= send_d;
      done_q    <= done_d;
    end
  end

  assign send      = send_q;
  assign id        = CAM_ID;
  assign regis     = regis_q;
  assign value     = value_q;
  assign done      = done_q;
  assign busy      = (state_q != S_DONE);
  assign cmd_index = addr_q;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Directed bench for ov7670_config_seq: one instance with a 4-cycle delay and
// one with a zero delay setting, sharing clock and reset.
module tb_ov7670_config_seq;

  logic       clk = 1'b0;
  logic       rst, start, taken, start0, taken0;
  logic       send, done, busy, send0, done0, busy0;
  logic [7:0] id, regis, value, id0, regis0, value0;
  logic [5:0] cmd_index, cmd_index0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ov7670_config_seq #(.CAM_ID(8'h42), .DELAY_CYCLES(24'd4)) dut (
    .clk(clk), .rst(rst), .start(start), .taken(taken), .send(send), .id(id),
    .regis(regis), .value(value), .done(done), .busy(busy), .cmd_index(cmd_index)
  );

  ov7670_config_seq #(.CAM_ID(8'h42), .DELAY_CYCLES(24'd0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .taken(taken0), .send(send0), .id(id0),
    .regis(regis0), .value(value0), .done(done0), .busy(busy0), .cmd_index(cmd_index0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Counts negedges with send low (including the current one) until send rises.
  task automatic wait_send(input bit spurious, output int gap);
    gap = 0;
    while (send !== 1'b1 && gap < 50) begin
      if (spurious && gap == 2) taken = 1'b1;
      @(negedge clk);
      taken = 1'b0;
      gap++;
    end
  endtask

  task automatic expect_cmd(input string tag, input logic [7:0] r, input logic [7:0] v,
                            input int exp_gap, input bit spurious);
    int gap;
    wait_send(spurious, gap);
    check({tag, "_gap"}, 32'(gap), 32'(exp_gap));
    check({tag, "_regis"}, 32'(regis), 32'(r));
    check({tag, "_value"}, 32'(value), 32'(v));
    $display("cmd %s regis=%02h value=%02h gap=%0d", tag, regis, value, gap);
  endtask

  task automatic pulse_taken();
    taken = 1'b1;
    @(negedge clk);
    taken = 1'b0;
  endtask

  initial begin
    int  n;
    bit  stable;
    rst = 1'b0; start = 1'b0; taken = 1'b0; start0 = 1'b0; taken0 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_send", 32'(send), 32'd0);
    check("rst_regis", 32'(regis), 32'hFF);
    check("rst_value", 32'(value), 32'hFF);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_index", 32'(cmd_index), 32'd0);
    check("rst_id", 32'(id), 32'h42);
    check("rst_id0", 32'(id0), 32'h42);
    rst = 1'b1;

    expect_cmd("c0", 8'h12, 8'h80, 1, 1'b0);
    pulse_taken();
    // Spurious taken lands while in DELAY.
    expect_cmd("c1", 8'h12, 8'h04, 6, 1'b1);
    pulse_taken();
    expect_cmd("c2", 8'h40, 8'hD0, 1, 1'b0);
    stable = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!(send === 1'b1 && regis === 8'h40 && value === 8'hD0)) stable = 1'b0;
    end
    check("stall_stable", 32'(stable), 32'd1);
    $display("stall 500 cycles on regis=40 stable=%0d", stable);
    pulse_taken();
    expect_cmd("c3", 8'h8C, 8'h00, 1, 1'b0);
    pulse_taken();
    expect_cmd("c4", 8'h11, 8'h01, 1, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_send", 32'({send, regis, value}), 32'({1'b1, 8'h11, 8'h01}));
    pulse_taken();
    expect_cmd("c5", 8'h0C, 8'h00, 1, 1'b0);
    pulse_taken();
    expect_cmd("c6", 8'h3E, 8'h00, 1, 1'b0);
    pulse_taken();

    n = 0;
    while (done !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", 32'(n), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_index", 32'(cmd_index), 32'd8);
    check("done_send", 32'(send), 32'd0);
    repeat (5) @(negedge clk);
    check("done_hold", 32'(done), 32'd1);
    $display("sequence done index=%0d busy=%0d", cmd_index, busy);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_done", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_index", 32'(cmd_index), 32'd0);
    expect_cmd("r0", 8'h12, 8'h80, 1, 1'b0);
    pulse_taken();
    expect_cmd("r1", 8'h12, 8'h04, 6, 1'b0);
    pulse_taken();
    expect_cmd("r2", 8'h40, 8'hD0, 1, 1'b0);
    pulse_taken();
    expect_cmd("r3", 8'h8C, 8'h00, 1, 1'b0);

    rst = 1'b0;
    #1;
    check("midrst_send", 32'(send), 32'd0);
    check("midrst_regis", 32'(regis), 32'hFF);
    check("midrst_value", 32'(value), 32'hFF);
    check("midrst_index", 32'(cmd_index), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    $display("mid-command reset send=%0d regis=%02h value=%02h", send, regis, value);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    expect_cmd("a0", 8'h12, 8'h80, 1, 1'b0);

    check("d0_send", 32'(send0), 32'd1);
    check("d0_cmd0", 32'({regis0, value0}), 32'h1280);
    taken0 = 1'b1;
    @(negedge clk);
    taken0 = 1'b0;
    n = 0;
    while (send0 !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("d0_gap", 32'(n), 32'd3);
    check("d0_cmd1", 32'({regis0, value0}), 32'h1204);
    $display("zero-delay cmd regis=%02h value=%02h gap=%0d", regis0, value0, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
